// File: rtl/hh_pkg.sv
// Shared constants for the Hodgkin-Huxley Euler integrator: Q-format widths,
// membrane constants, reset values, FSM encodings and multiplier shift codes.
package hh_pkg;

  // Q-formats: voltage and rates are signed Q8.5, gates are unsigned Q1.13.
  localparam int V_W    = 14;
  localparam int V_FRAC = 5;
  localparam int G_W    = 14;
  localparam int G_FRAC = 13;

  // Multiplier operands carry one extra bit so that 1.0 (8192) and V - E fit
  // without wrapping; products saturate into a 20-bit signed accumulator.
  localparam int OP_W   = G_W + 1;
  localparam int PROD_W = 2 * OP_W;
  localparam int ACC_W  = 20;

  // Reversal potentials (Q8.5 mV) and conductances (mS/cm^2, integer/Q8.5).
  localparam logic signed [OP_W-1:0] E_NA = OP_W'(1600);
  localparam logic signed [OP_W-1:0] E_K  = OP_W'(-2464);
  localparam logic signed [OP_W-1:0] E_L  = OP_W'(-1740);
  localparam logic signed [OP_W-1:0] G_NA = OP_W'(120);
  localparam logic signed [OP_W-1:0] G_K  = OP_W'(36);
  localparam logic signed [OP_W-1:0] G_L  = OP_W'(10);

  // Resting state: -65 mV and the matching steady-state gates.
  localparam logic signed [V_W-1:0] V_RST    = V_W'(-2080);
  localparam logic [G_W-1:0]        N_RST    = G_W'(2603);
  localparam logic [G_W-1:0]        M_RST    = G_W'(433);
  localparam logic [G_W-1:0]        H_RST    = G_W'(4883);
  localparam logic [G_W-1:0]        GATE_ONE = G_W'(8192);

  // Step sequencer states.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_GATE = 3'd1;
  localparam logic [2:0] ST_CURR = 3'd2;
  localparam logic [2:0] ST_VOLT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Post-multiply arithmetic right shift selection.
  typedef enum logic [1:0] {
    SH_0  = 2'd0,
    SH_5  = 2'd1,
    SH_13 = 2'd2
  } mac_shift_e;

endpackage

// File: rtl/hh_integrator_if.sv
// Request/response bundle between the integrator and its neighbours: rate
// inputs from hh_state, stimulus, step handshake and the neuron state outputs.
interface hh_integrator_if
  import hh_pkg::*;
#(
  parameter int W = 14
);

  logic signed [W-1:0] alpha_n;
  logic signed [W-1:0] alpha_m;
  logic signed [W-1:0] alpha_h;
  logic signed [W-1:0] beta_n;
  logic signed [W-1:0] beta_m;
  logic signed [W-1:0] beta_h;
  logic signed [W-1:0] i_stim;
  logic                step_start;
  logic signed [W-1:0] voltage;
  logic [G_W-1:0]      gate_n;
  logic [G_W-1:0]      gate_m;
  logic [G_W-1:0]      gate_h;
  logic                busy;
  logic                step_done;
  logic                spike;

  modport master (
    output alpha_n, alpha_m, alpha_h, beta_n, beta_m, beta_h, i_stim, step_start,
    input  voltage, gate_n, gate_m, gate_h, busy, step_done, spike
  );

  modport slave (
    input  alpha_n, alpha_m, alpha_h, beta_n, beta_m, beta_h, i_stim, step_start,
    output voltage, gate_n, gate_m, gate_h, busy, step_done, spike
  );

endinterface

// File: rtl/hh_mac.sv
// Shared signed multiplier: full-precision product, arithmetic right shift by
// 0, 5 or 13 (floor toward -inf), then saturation into the 20-bit accumulator.
module hh_mac
  import hh_pkg::*;
(
  input  logic signed [OP_W-1:0]  a,
  input  logic signed [OP_W-1:0]  b,
  input  mac_shift_e              shift,
  output logic signed [ACC_W-1:0] y
);

  localparam logic signed [PROD_W-1:0] Y_MAX = PROD_W'((1 <<< (ACC_W-1)) - 1);
  localparam logic signed [PROD_W-1:0] Y_MIN = PROD_W'(-(1 <<< (ACC_W-1)));

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;

  function automatic logic signed [ACC_W-1:0] sat_prod(input logic signed [PROD_W-1:0] v);
    if (v > Y_MAX)      sat_prod = {1'b0, {(ACC_W-1){1'b1}}};
    else if (v < Y_MIN) sat_prod = {1'b1, {(ACC_W-1){1'b0}}};
    else                sat_prod = v[ACC_W-1:0];
  endfunction

  // Multiply, scale and clip in one combinational pass.
  always_comb begin
    prod = PROD_W'(a) * PROD_W'(b);
    case (shift)
      SH_5:    shifted = prod >>> V_FRAC;
      SH_13:   shifted = prod >>> G_FRAC;
      default: shifted = prod;
    endcase
    y = sat_prod(shifted);
  end

endmodule

// File: rtl/hh_integrator.sv
// Forward-Euler Hodgkin-Huxley step engine. One shared multiplier is walked
// through 6 gate cycles and 10 current cycles, then the new membrane voltage
// and gates are committed together, giving an 18-cycle step.
module hh_integrator
  import hh_pkg::*;
#(
  parameter int DT_SHIFT = 5,
  parameter int W        = 14
)(
  input logic             clk,
  input logic             rst,
  hh_integrator_if.slave  bus
);

  localparam int GATE_SHIFT = V_FRAC + DT_SHIFT;
  localparam int GS_W       = ACC_W + 2;
  localparam int VS_W       = ACC_W + 3;

  localparam logic signed [ACC_W:0]  ACC_MAX  = (ACC_W+1)'((1 <<< (ACC_W-1)) - 1);
  localparam logic signed [ACC_W:0]  ACC_MIN  = (ACC_W+1)'(-(1 <<< (ACC_W-1)));
  localparam logic signed [GS_W-1:0] GSUM_ONE = GS_W'(GATE_ONE);
  localparam logic signed [VS_W-1:0] V_MAX    = VS_W'((1 <<< (W-1)) - 1);
  localparam logic signed [VS_W-1:0] V_MIN    = VS_W'(-(1 <<< (W-1)));

  // Control and architectural state
  logic [2:0]          state;
  logic [3:0]          sub_cnt;
  logic                busy_q;
  logic                done_q;
  logic                spike_q;
  logic signed [W-1:0] v_q;
  logic [G_W-1:0]      gn_q, gm_q, gh_q;

  // Step-local data (snapshots, working gates, product pipeline)
  logic signed [W-1:0]     an_s, am_s, ah_s, bn_s, bm_s, bh_s, istim_s;
  logic [G_W-1:0]          gn_w, gm_w, gh_w;
  logic signed [ACC_W-1:0] prod_p1;
  logic signed [ACC_W-1:0] acc;

  // Combinational datapath
  logic signed [OP_W-1:0]  mac_a, mac_b;
  mac_shift_e              mac_sh;
  logic signed [ACC_W-1:0] mac_y;
  logic signed [OP_W-1:0]  prod_op;
  logic signed [OP_W-1:0]  v_op;
  logic [G_W-1:0]          x_cur;
  logic signed [W-1:0]     rate_a, rate_b;
  logic signed [ACC_W:0]   gdiff;
  logic signed [GS_W-1:0]  gsum;
  logic [G_W-1:0]          x_new;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [VS_W-1:0]  vdiff;
  logic signed [VS_W-1:0]  vsum;
  logic signed [W-1:0]     v_new;
  logic                    accept;

  function automatic logic signed [W-1:0] clamp_rate(input logic signed [W-1:0] r);
    clamp_rate = r[W-1] ? '0 : r;
  endfunction

  function automatic logic signed [OP_W-1:0] gate_op(input logic [G_W-1:0] g);
    gate_op = $signed({1'b0, g});
  endfunction

  function automatic logic [G_W-1:0] clamp_gate(input logic signed [GS_W-1:0] s);
    if (s[GS_W-1])         clamp_gate = '0;
    else if (s > GSUM_ONE) clamp_gate = GATE_ONE;
    else                   clamp_gate = s[G_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    if (s > ACC_MAX)      sat_acc = {1'b0, {(ACC_W-1){1'b1}}};
    else if (s < ACC_MIN) sat_acc = {1'b1, {(ACC_W-1){1'b0}}};
    else                  sat_acc = s[ACC_W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat_v(input logic signed [VS_W-1:0] s);
    if (s > V_MAX)      sat_v = {1'b0, {(W-1){1'b1}}};
    else if (s < V_MIN) sat_v = {1'b1, {(W-1){1'b0}}};
    else                sat_v = s[W-1:0];
  endfunction

  assign accept  = (state == ST_IDLE) && bus.step_start;
  assign prod_op = prod_p1[OP_W-1:0];
  assign v_op    = OP_W'(v_q);

  hh_mac u_mac (
    .a     (mac_a),
    .b     (mac_b),
    .shift (mac_sh),
    .y     (mac_y)
  );

  // Route snapshot rates, working gates, voltage and the last product into the multiplier.
  always_comb begin
    x_cur  = gn_w;
    rate_a = an_s;
    rate_b = bn_s;
    case (sub_cnt[2:1])
      2'd1: begin x_cur = gm_w; rate_a = am_s; rate_b = bm_s; end
      2'd2: begin x_cur = gh_w; rate_a = ah_s; rate_b = bh_s; end
      default: ;
    endcase

    mac_a  = '0;
    mac_b  = '0;
    mac_sh = SH_0;
    if (state == ST_GATE) begin
      if (!sub_cnt[0]) begin
        mac_a = OP_W'(rate_a);
        mac_b = gate_op(GATE_ONE) - gate_op(x_cur);
      end else begin
        mac_a = OP_W'(rate_b);
        mac_b = gate_op(x_cur);
      end
    end else if (state == ST_CURR) begin
      case (sub_cnt)
        4'd0: begin mac_a = gate_op(gm_w); mac_b = gate_op(gm_w); mac_sh = SH_13; end
        4'd1: begin mac_a = prod_op;       mac_b = gate_op(gm_w); mac_sh = SH_13; end
        4'd2: begin mac_a = prod_op;       mac_b = gate_op(gh_w); mac_sh = SH_13; end
        4'd3: begin mac_a = prod_op;       mac_b = v_op - E_NA;   mac_sh = SH_13; end
        4'd4: begin mac_a = G_NA;          mac_b = prod_op;       mac_sh = SH_0;  end
        4'd5: begin mac_a = gate_op(gn_w); mac_b = gate_op(gn_w); mac_sh = SH_13; end
        4'd6: begin mac_a = prod_op;       mac_b = prod_op;       mac_sh = SH_13; end
        4'd7: begin mac_a = prod_op;       mac_b = v_op - E_K;    mac_sh = SH_13; end
        4'd8: begin mac_a = G_K;           mac_b = prod_op;       mac_sh = SH_0;  end
        4'd9: begin mac_a = G_L;           mac_b = v_op - E_L;    mac_sh = SH_5;  end
        default: ;
      endcase
    end
  end

  // Euler gate update: p1 (alpha term) is in prod_p1, p2 (beta term) is on the multiplier now.
  always_comb begin
    gdiff = (ACC_W+1)'(prod_p1) - (ACC_W+1)'(mac_y);
    gsum  = GS_W'(gate_op(x_cur)) + GS_W'(gdiff >>> GATE_SHIFT);
    x_new = clamp_gate(gsum);
  end

  // Accumulate the latest current term and form the next membrane voltage.
  always_comb begin
    acc_sum = sat_acc((ACC_W+1)'(acc) + (ACC_W+1)'(prod_p1));
    vdiff   = VS_W'(istim_s) - VS_W'(acc_sum);
    vsum    = VS_W'(v_q) + (vdiff >>> DT_SHIFT);
    v_new   = sat_v(vsum);
  end

  // Step sequencer and committed outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sub_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      spike_q <= 1'b0;
      v_q     <= V_RST;
      gn_q    <= N_RST;
      gm_q    <= M_RST;
      gh_q    <= H_RST;
    end else begin
      done_q  <= 1'b0;
      spike_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.step_start) begin
            state   <= ST_GATE;
            sub_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_GATE: begin
          if (sub_cnt == 4'd5) begin
            state   <= ST_CURR;
            sub_cnt <= '0;
          end else begin
            sub_cnt <= sub_cnt + 4'd1;
          end
        end
        ST_CURR: begin
          if (sub_cnt == 4'd9) begin
            state   <= ST_VOLT;
            sub_cnt <= '0;
          end else begin
            sub_cnt <= sub_cnt + 4'd1;
          end
        end
        ST_VOLT: begin
          v_q     <= v_new;
          gn_q    <= gn_w;
          gm_q    <= gm_w;
          gh_q    <= gh_w;
          done_q  <= 1'b1;
          spike_q <= (v_q[W-1] || (v_q == '0)) && !v_new[W-1] && (v_new != '0);
          state   <= ST_DONE;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0 -> p1: input snapshot, working gates, registered product and accumulator.
  always_ff @(posedge clk) begin
    prod_p1 <= mac_y;
    if (accept) begin
      an_s    <= clamp_rate(bus.alpha_n);
      am_s    <= clamp_rate(bus.alpha_m);
      ah_s    <= clamp_rate(bus.alpha_h);
      bn_s    <= clamp_rate(bus.beta_n);
      bm_s    <= clamp_rate(bus.beta_m);
      bh_s    <= clamp_rate(bus.beta_h);
      istim_s <= bus.i_stim;
      gn_w    <= gn_q;
      gm_w    <= gm_q;
      gh_w    <= gh_q;
    end
    if (state == ST_GATE && sub_cnt[0]) begin
      case (sub_cnt[2:1])
        2'd0:    gn_w <= x_new;
        2'd1:    gm_w <= x_new;
        default: gh_w <= x_new;
      endcase
    end
    if (state == ST_CURR && sub_cnt == 4'd5) begin
      acc <= prod_p1;
    end else if (state == ST_CURR && sub_cnt == 4'd9) begin
      acc <= acc_sum;
    end
  end

  assign bus.voltage   = v_q;
  assign bus.gate_n    = gn_q;
  assign bus.gate_m    = gm_q;
  assign bus.gate_h    = gh_q;
  assign bus.busy      = busy_q;
  assign bus.step_done = done_q;
  assign bus.spike     = spike_q;

endmodule

// File: tb/tb_hh_integrator.sv
// Self-checking bench for hh_integrator: randomized steps compared against a
// plain-arithmetic Euler model, plus timing, re-trigger, saturation and abort.
module tb_hh_integrator;

  logic clk = 1'b0;
  logic rst;

  hh_integrator_if #(.W(14)) bus ();

  hh_integrator #(.DT_SHIFT(5), .W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference neuron state
  longint mv, mn, mm, mh;
  bit     mspk;
  bit     last_spk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint sat(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic longint pos(input longint v);
    return (v < 0) ? 0 : v;
  endfunction

  // Multiply, floor-scale by 2^sh, clip to the 20-bit signed accumulator range.
  function automatic longint mul(input longint a, input longint b, input int sh);
    return sat((a * b) >>> sh, -524288, 524287);
  endfunction

  // dx = dt * (alpha*(1-x) - beta*x), in Q1.13 with dt = 1/32 ms and rates in Q8.5.
  function automatic longint gate_upd(input longint x, input longint a, input longint b);
    longint p1 = mul(a, 8192 - x, 0);
    longint p2 = mul(b, x, 0);
    return sat(x + ((p1 - p2) >>> 10), 0, 8192);
  endfunction

  task automatic model_reset();
    mv = -2080; mn = 2603; mm = 433; mh = 4883;
  endtask

  task automatic model_step(input longint an, input longint am, input longint ah,
                            input longint bn, input longint bm, input longint bh,
                            input longint is);
    longint tna, tk, cur, vn;
    mn  = gate_upd(mn, pos(an), pos(bn));
    mm  = gate_upd(mm, pos(am), pos(bm));
    mh  = gate_upd(mh, pos(ah), pos(bh));
    tna = mul(mul(mul(mul(mm, mm, 13), mm, 13), mh, 13), mv - 1600, 13);
    tk  = mul(mul(mul(mn, mn, 13), mul(mn, mn, 13), 13), mv + 2464, 13);
    cur = mul(120, tna, 0);
    cur = sat(cur + mul(36, tk, 0), -524288, 524287);
    cur = sat(cur + mul(10, mv + 1740, 5), -524288, 524287);
    vn  = sat(mv + ((is - cur) >>> 5), -8192, 8191);
    mspk = (mv <= 0) && (vn > 0);
    mv  = vn;
  endtask

  task automatic set_inputs(input int an, input int am, input int ah,
                            input int bn, input int bm, input int bh, input int is);
    bus.alpha_n = 14'(an); bus.alpha_m = 14'(am); bus.alpha_h = 14'(ah);
    bus.beta_n  = 14'(bn); bus.beta_m  = 14'(bm); bus.beta_h  = 14'(bh);
    bus.i_stim  = 14'(is);
  endtask

  task automatic rand_inputs();
    set_inputs(int'($urandom_range(0, 1564)) - 64, int'($urandom_range(0, 1564)) - 64,
               int'($urandom_range(0, 1564)) - 64, int'($urandom_range(0, 1564)) - 64,
               int'($urandom_range(0, 1564)) - 64, int'($urandom_range(0, 1564)) - 64,
               int'($urandom_range(0, 6000)) - 2000);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_voltage"}, bus.voltage, -2080);
    chk({tag, "_gate_n"}, bus.gate_n, 2603);
    chk({tag, "_gate_m"}, bus.gate_m, 433);
    chk({tag, "_gate_h"}, bus.gate_h, 4883);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_step_done"}, bus.step_done, 0);
    chk({tag, "_spike"}, bus.spike, 0);
  endtask

  // Hold reset for three edges; returns just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    model_reset();
  endtask

  // One step over a fixed 25-edge window; must be entered just after a falling edge.
  task automatic do_step(input bit repulse, input bit scramble);
    longint v_pre = mv;
    longint n_pre = mn;
    int done_at  = -1;
    int busy_cnt = 0;
    int done_cnt = 0;
    bit spk      = 1'b0;
    model_step(longint'(bus.alpha_n), longint'(bus.alpha_m), longint'(bus.alpha_h),
               longint'(bus.beta_n), longint'(bus.beta_m), longint'(bus.beta_h),
               longint'(bus.i_stim));
    bus.step_start = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.step_done) begin
        done_cnt++;
        done_at = k;
      end
      if (bus.spike) spk = 1'b1;
      if (k == 8) begin
        chk("mid_voltage_hold", bus.voltage, v_pre);
        chk("mid_gate_n_hold", bus.gate_n, n_pre);
      end
      bus.step_start = repulse && (k == 2 || k == 16 || k == 17);
      if (scramble && k == 0) rand_inputs();
    end
    chk("done_latency", done_at, 17);
    chk("busy_cycles", busy_cnt, 18);
    chk("done_count", done_cnt, 1);
    chk("voltage", bus.voltage, mv);
    chk("gate_n", bus.gate_n, mn);
    chk("gate_m", bus.gate_m, mm);
    chk("gate_h", bus.gate_h, mh);
    chk("spike", spk, mspk);
    last_spk = spk;
  endtask

  initial begin
    int spikes;
    int wrapped;
    bit crossed;
    int ab_done;
    int ab_busy;

    rst = 1'b1;
    bus.step_start = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset values
    do_reset();

    // Zero rates: gates must not move
    do_step(1'b0, 1'b0);
    chk("zero_rate_gate_n", bus.gate_n, 2603);
    chk("zero_rate_gate_m", bus.gate_m, 433);
    chk("zero_rate_gate_h", bus.gate_h, 4883);

    // Single alpha_n step from rest
    do_reset();
    set_inputs(32, 0, 0, 0, 0, 0, 0);
    do_step(1'b0, 1'b0);
    chk("alpha_n_step", bus.gate_n, 2777);

    // Re-pulsed step_start during and at the end of a step is ignored
    do_reset();
    rand_inputs();
    do_step(1'b1, 1'b0);

    // Randomized steps, half of them with inputs changing mid-step
    for (int i = 0; i < 30; i++) begin
      rand_inputs();
      do_step(1'b0, i[0]);
    end

    // Strong stimulus drives voltage into positive saturation
    do_reset();
    set_inputs(0, 0, 0, 8191, 8191, 0, 8191);
    spikes  = 0;
    wrapped = 0;
    crossed = 1'b0;
    for (int i = 0; i < 80; i++) begin
      do_step(1'b0, 1'b0);
      if (last_spk) spikes++;
      if (crossed && bus.voltage < 0) wrapped++;
      if (bus.voltage > 0) crossed = 1'b1;
    end
    chk("sat_spike_count", spikes, 1);
    chk("sat_no_wrap", wrapped, 0);
    chk("sat_voltage_max", bus.voltage, 8191);

    // Reset in the middle of a step aborts it
    do_reset();
    rand_inputs();
    bus.step_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.step_start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("abort");
    rst = 1'b0;
    ab_done = 0;
    ab_busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.step_done) ab_done++;
      if (bus.busy) ab_busy++;
    end
    chk("abort_no_done", ab_done, 0);
    chk("abort_no_busy", ab_busy, 0);
    model_reset();
    rand_inputs();
    do_step(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
